// File: rtl/round_sd_tdm.sv
// Round-robin TDM front end feeding one shared rounding engine. Each channel keeps
// its own rounding residue, which is added to that channel's next sample (sigma-delta).
module round_sd_tdm #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH_IN   = 18,
  parameter int WIDTH_OUT  = 16,
  parameter int DISABLE_SD = 0,
  localparam int D         = WIDTH_IN - WIDTH_OUT,
  localparam int ERR_WIDTH = D + 1,
  localparam int CH_W      = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*WIDTH_IN-1:0] in_tdata,
  input  logic [NUM_CH-1:0]          in_tvalid,
  output logic [NUM_CH-1:0]          in_tready,
  input  logic                       clear_err,
  output logic [WIDTH_OUT-1:0]       out_tdata,
  output logic [CH_W-1:0]            out_tuser,
  output logic                       out_tvalid,
  input  logic                       out_tready
);

  localparam int SW = WIDTH_IN + 1;

  logic [CH_W-1:0]                  last_grant_q, last_grant_d;
  logic                             a_valid_q, a_valid_d;
  logic [WIDTH_IN-1:0]              a_data_q, a_data_d;
  logic [CH_W-1:0]                  a_ch_q, a_ch_d;
  logic                             out_tvalid_q, out_tvalid_d;
  logic [WIDTH_OUT-1:0]             out_tdata_q, out_tdata_d;
  logic [CH_W-1:0]                  out_tuser_q, out_tuser_d;
  logic [NUM_CH-1:0][ERR_WIDTH-1:0] err_q, err_d;

  logic                 grant_any;
  logic [CH_W-1:0]      grant_idx, cand;
  logic [NUM_CH-1:0]    grant;
  logic                 adv_a, adv_b, accept;
  logic [ERR_WIDTH-1:0] err_rd, e_new;
  logic [SW-1:0]        sum_w;
  logic [WIDTH_IN-1:0]  s_sat;
  logic [WIDTH_OUT:0]   r_w;
  logic [WIDTH_OUT-1:0] r_sat;

  // Search starts one past the last granted channel so every channel gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant_q) + k) % NUM_CH);
      if (!grant_any && in_tvalid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant     = grant_any ? (NUM_CH'(1) << grant_idx) : '0;
  assign adv_b     = !out_tvalid_q || out_tready;
  assign adv_a     = !a_valid_q || adv_b;
  assign in_tready = (reset || !adv_a) ? '0 : grant;
  assign accept    = |in_tready;

  always_comb begin
    last_grant_d = last_grant_q;
    a_valid_d    = a_valid_q;
    a_data_d     = a_data_q;
    a_ch_d       = a_ch_q;
    if (accept) last_grant_d = grant_idx;
    if (adv_a) begin
      a_valid_d = accept;
      if (accept) begin
        a_data_d = in_tdata[grant_idx*WIDTH_IN +: WIDTH_IN];
        a_ch_d   = grant_idx;
      end
    end
  end

  always_comb begin
    err_rd = (DISABLE_SD != 0) ? '0 : err_q[a_ch_q];
    sum_w  = {a_data_q[WIDTH_IN-1], a_data_q}
           + {{(SW-ERR_WIDTH){err_rd[ERR_WIDTH-1]}}, err_rd};
    if (sum_w[SW-1] != sum_w[SW-2]) s_sat = {sum_w[SW-1], {(WIDTH_IN-1){~sum_w[SW-1]}}};
    else                            s_sat = sum_w[WIDTH_IN-1:0];
    // Adding half an LSB then shifting equals floor(S/2^D) plus bit D-1 of S.
    r_w = {s_sat[WIDTH_IN-1], s_sat[WIDTH_IN-1:D]} + {{WIDTH_OUT{1'b0}}, s_sat[D-1]};
    if (r_w[WIDTH_OUT] != r_w[WIDTH_OUT-1]) r_sat = {r_w[WIDTH_OUT], {(WIDTH_OUT-1){~r_w[WIDTH_OUT]}}};
    else                                    r_sat = r_w[WIDTH_OUT-1:0];
    // Residue fits in ERR_WIDTH bits, so only the low bits of S - (R << D) matter.
    e_new = s_sat[D:0] - {r_sat[0], {D{1'b0}}};

    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    out_tuser_d  = out_tuser_q;
    err_d        = err_q;
    if (adv_b) begin
      out_tvalid_d = a_valid_q;
      if (a_valid_q) begin
        out_tdata_d = r_sat;
        out_tuser_d = a_ch_q;
        if (DISABLE_SD == 0) err_d[a_ch_q] = e_new;
      end
    end
    if (clear_err) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= CH_W'(NUM_CH - 1);
      a_valid_q    <= 1'b0;
      a_data_q     <= '0;
      a_ch_q       <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tuser_q  <= '0;
      err_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      a_valid_q    <= a_valid_d;
      a_data_q     <= a_data_d;
      a_ch_q       <= a_ch_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tuser_q  <= out_tuser_d;
      err_q        <= err_d;
    end
  end

  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = out_tdata_q;
  assign out_tuser  = out_tuser_q;

endmodule

// File: tb/tb_round_sd_tdm.sv
// Scoreboard bench for round_sd_tdm: one instance with error feedback, one with
// DISABLE_SD=1, both on the same stimulus.
module tb_round_sd_tdm;
  localparam int NC = 4, WI = 18, WO = 16;

  logic clk = 1'b0;
  logic reset, clear_err, out_tready;
  logic [NC*WI-1:0] in_tdata;
  logic [NC-1:0] in_tvalid, in_tready, in_tready_n;
  logic [WO-1:0] out_tdata, out_tdata_n;
  logic [1:0] out_tuser, out_tuser_n;
  logic out_tvalid, out_tvalid_n;

  always #5 clk = ~clk;

  round_sd_tdm #(.NUM_CH(NC), .WIDTH_IN(WI), .WIDTH_OUT(WO), .DISABLE_SD(0)) dut (
    .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready), .clear_err(clear_err), .out_tdata(out_tdata),
    .out_tuser(out_tuser), .out_tvalid(out_tvalid), .out_tready(out_tready));

  round_sd_tdm #(.NUM_CH(NC), .WIDTH_IN(WI), .WIDTH_OUT(WO), .DISABLE_SD(1)) dut_n (
    .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready_n), .clear_err(clear_err), .out_tdata(out_tdata_n),
    .out_tuser(out_tuser_n), .out_tvalid(out_tvalid_n), .out_tready(out_tready));

  typedef struct { int d; int dn; int ch; int cyc; } exp_t;
  exp_t sb[$];
  exp_t px;
  int total = 0, bad = 0, cyc = 0, acc_cnt = 0, base = 0;
  bit lat_chk = 1'b0;
  int m_err[NC];
  int m_last = NC - 1;
  int got_d[$], got_n[$], got_u[$], exp_q[$];
  bit stall_q = 1'b0;
  logic [WO-1:0] hold_d;
  logic [1:0] hold_u;
  int a_ch, a_pg, a_x, a_r, a_rn, a_e;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference rounding with explicit floor division.
  function automatic int model(input int x, input int e, output int enew);
    int s, t, q;
    s = x + e;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    t = s + 2;
    q = t / 4;
    if (t < 0 && (t % 4) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    enew = s - q * 4;
    return q;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Acceptance monitor: predicts the grant and pushes the expected output.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      sb.delete();
      foreach (m_err[i]) m_err[i] = 0;
      m_last = NC - 1;
    end else begin
      if (in_tvalid != 0) begin
        chk("tready_onehot", int'($onehot0(in_tready)), 1);
        chk("tready_nosd", int'(in_tready_n), int'(in_tready));
      end
      if ((in_tvalid & in_tready) != 0) begin
        a_pg = -1;
        for (int k = 1; k <= NC; k++)
          if (a_pg < 0 && in_tvalid[2'((m_last + k) % NC)]) a_pg = (m_last + k) % NC;
        a_ch = 0;
        for (int i = 0; i < NC; i++) if (in_tready[i]) a_ch = i;
        chk("rr_grant", a_ch, a_pg);
        a_x  = int'($signed(in_tdata[a_ch*WI +: WI]));
        a_rn = model(a_x, 0, a_e);
        a_r  = model(a_x, m_err[a_ch], a_e);
        m_err[a_ch] = a_e;
        sb.push_back('{a_r, a_rn, a_ch, cyc});
        m_last = a_ch;
        acc_cnt++;
      end
      if (clear_err) foreach (m_err[i]) m_err[i] = 0;
    end
  end

  // Output monitor: pops on each handshake, checks hold stability under stall.
  initial forever begin
    @(negedge clk);
    if (reset) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_valid", int'(out_tvalid), 1);
        chk("hold_data", int'(out_tdata), int'(hold_d));
        chk("hold_user", int'(out_tuser), int'(hold_u));
      end
      if (out_tvalid && out_tready) begin
        chk("out_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          px = sb.pop_front();
          chk("out_data", int'($signed(out_tdata)), px.d);
          chk("out_user", int'(out_tuser), px.ch);
          chk("nosd_valid", int'(out_tvalid_n), 1);
          chk("nosd_data", int'($signed(out_tdata_n)), px.dn);
          if (lat_chk) chk("latency", cyc - px.cyc, 2);
        end
        got_d.push_back(int'($signed(out_tdata)));
        got_n.push_back(int'($signed(out_tdata_n)));
        got_u.push_back(int'(out_tuser));
      end
      stall_q = out_tvalid && !out_tready;
      hold_d  = out_tdata;
      hold_u  = out_tuser;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int v);
    in_tdata[c*WI +: WI] = WI'(v);
  endtask

  task automatic pulse_clear;
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  task automatic clear_logs;
    got_d.delete(); got_n.delete(); got_u.delete();
  endtask

  task automatic check_seq(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    foreach (exp[i]) if (i < act.size()) chk(nm, act[i], exp[i]);
  endtask

  initial begin
    reset = 1'b1; clear_err = 1'b0; out_tready = 1'b1;
    in_tvalid = '0; in_tdata = '0;
    tick(2);
    in_tvalid = '1;
    tick(1);
    chk("rst_out_tvalid", int'(out_tvalid), 0);
    chk("rst_out_tdata", int'(out_tdata), 0);
    chk("rst_out_tuser", int'(out_tuser), 0);
    chk("rst_in_tready", int'(in_tready), 0);
    chk("rst_err", int'(dut.err_q), 0);
    in_tvalid = '0;
    reset = 1'b0;
    tick(1);

    // All channels valid: one per cycle in channel order starting at 0.
    lat_chk = 1'b1;
    clear_logs();
    set_ch(0, 100); set_ch(1, -7); set_ch(2, 131071); set_ch(3, 3);
    base = acc_cnt;
    in_tvalid = 4'hF;
    tick(12);
    in_tvalid = '0;
    chk("throughput", acc_cnt - base, 12);
    tick(4);
    exp_q = '{0,1,2,3,0,1,2,3,0,1,2,3};
    check_seq("rr_order", got_u, exp_q);

    // Channel 0, input 5 repeated: 1,2,1,1 cycle, leaving err[0]=1 after 9 samples.
    pulse_clear();
    clear_logs();
    set_ch(0, 5);
    in_tvalid = 4'b0001;
    tick(9);
    in_tvalid = '0;
    tick(4);
    exp_q = '{1,2,1,1,1,2,1,1,1};
    check_seq("sd_seq", got_d, exp_q);
    exp_q = '{1,1,1,1,1,1,1,1,1};
    check_seq("nosd_seq", got_n, exp_q);
    chk("err0_after", int'($signed(dut.err_q[0])), 1);
    pulse_clear();
    chk("err0_cleared", int'(dut.err_q[0]), 0);
    clear_logs();
    in_tvalid = 4'b0001;
    tick(2);
    in_tvalid = '0;
    tick(4);
    exp_q = '{1,2};
    check_seq("post_clear", got_d, exp_q);

    // Saturation at both ends on channel 1.
    pulse_clear();
    clear_logs();
    set_ch(1, 131071);
    in_tvalid = 4'b0010;
    tick(4);
    in_tvalid = '0;
    tick(4);
    exp_q = '{32767,32767,32767,32767};
    check_seq("sat_pos", got_d, exp_q);
    chk("err1_pos", int'($signed(dut.err_q[1])), 3);
    pulse_clear();
    clear_logs();
    set_ch(1, -131072);
    in_tvalid = 4'b0010;
    tick(3);
    in_tvalid = '0;
    tick(4);
    exp_q = '{-32768,-32768,-32768};
    check_seq("sat_neg", got_d, exp_q);
    chk("err1_neg", int'(dut.err_q[1]), 0);

    // Backpressure: two samples fill the pipe, then nothing until release.
    lat_chk = 1'b0;
    clear_logs();
    set_ch(0, 10); set_ch(1, -10); set_ch(2, 1000); set_ch(3, -1001);
    out_tready = 1'b0;
    base = acc_cnt;
    in_tvalid = 4'hF;
    tick(5);
    chk("stall_accepts", acc_cnt - base, 2);
    chk("stall_tready", int'(in_tready), 0);
    out_tready = 1'b1;
    tick(6);
    in_tvalid = '0;
    tick(4);
    exp_q = '{2,3,0,1,2,3,0,1};
    check_seq("stall_order", got_u, exp_q);
    chk("stall_drained", sb.size(), 0);

    // Reset with both stages full discards in-flight data.
    set_ch(0, 5); set_ch(1, 5); set_ch(2, 5); set_ch(3, 5);
    out_tready = 1'b0;
    in_tvalid = 4'hF;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("midrst_tvalid", int'(out_tvalid), 0);
    chk("midrst_tvalid_n", int'(out_tvalid_n), 0);
    chk("midrst_tready", int'(in_tready), 0);
    chk("midrst_err", int'(dut.err_q), 0);
    reset = 1'b0;
    out_tready = 1'b1;
    lat_chk = 1'b1;
    clear_logs();
    tick(4);
    in_tvalid = '0;
    tick(4);
    exp_q = '{0,1,2,3};
    check_seq("postrst_order", got_u, exp_q);
    exp_q = '{1,1,1,1};
    check_seq("postrst_data", got_d, exp_q);
    chk("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
